mem_stage: RTL

//  Pipeline stage directly downstream of EX. Registers the ALU result and control fields.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/mem_timeout_cnt.sv | 30 +++
 rtl/mem_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM stage state encoding and default datapath widths.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/enable cycle counter for the data-memory handshake watchdog.
// term flags the enabled cycle whose increment reaches TIMEOUT.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic term
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = en && (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, runs data-memory req/ack accesses
// with stall and timeout, and presents registered writeback fields to WB.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned REG_W   = DEF_REG_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic              reg_we,
    input  logic [REG_W-1:0]  dst_reg,
    input  logic              flush,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_we,
    output logic [REG_W-1:0]  wb_dst_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    mem_state_t       state;
    logic             mem_op;
    logic             aligned;
    logic             start;
    logic             timeout_hit;
    logic             kill_q;
    logic             reg_we_q;
    logic [REG_W-1:0] dst_q;
    logic             unused_hi;

    assign mem_op    = in_valid && (mem_re || mem_we) && !flush;
    assign aligned   = (alu_result[1:0] == 2'b00);
    assign start     = (state == MEM_IDLE) && mem_op && aligned;
    // Upstream is released in the cycle the access ends, by ack or by timeout.
    assign stall_out = start || ((state == MEM_ACCESS) && !dmem_ack && !timeout_hit);
    assign unused_hi = ^alu_result[DATA_W-1:ADDR_W+2];

    mem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state != MEM_ACCESS),
        .en   ((state == MEM_ACCESS) && !dmem_ack),
        .term (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MEM_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            kill_q     <= 1'b0;
            reg_we_q   <= 1'b0;
            dst_q      <= '0;
            wb_valid   <= 1'b0;
            wb_reg_we  <= 1'b0;
            wb_dst_reg <= '0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_reg_we  <= 1'b0;
            wb_dst_reg <= '0;
            wb_data    <= '0;
            mem_err    <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (mem_op) begin
                        if (aligned) begin
                            state      <= MEM_ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_we;
                            dmem_addr  <= alu_result[ADDR_W+1:2];
                            dmem_wdata <= store_data;
                            dst_q      <= dst_reg;
                            reg_we_q   <= reg_we && !mem_we;
                            kill_q     <= 1'b0;
                        end else begin
                            mem_err <= 1'b1;
                        end
                    end else if (in_valid && !flush) begin
                        wb_valid   <= 1'b1;
                        wb_reg_we  <= reg_we;
                        wb_dst_reg <= dst_reg;
                        wb_data    <= alu_result;
                    end
                end
                MEM_ACCESS: begin
                    kill_q <= kill_q || flush;
                    if (dmem_ack) begin
                        state    <= MEM_IDLE;
                        dmem_req <= 1'b0;
                        if (!(kill_q || flush)) begin
                            wb_valid   <= 1'b1;
                            wb_reg_we  <= reg_we_q;
                            wb_dst_reg <= dst_q;
                            wb_data    <= dmem_we ? '0 : dmem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state    <= MEM_IDLE;
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule
